// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, FSM encoding and output clamp
// for the linear-mode CORDIC multiply-accumulate datapath.
package cordic_pkg;

    localparam int DEF_WIDTH = 15;
    localparam int DEF_FRAC  = 12;
    localparam int DEF_ITER  = 13;
    localparam int DEF_GUARD = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp v into the signed range of an (msb+1)-bit word.
    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] v,
        input int                 msb
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< msb) - 32'sd1;
        lo = -(32'sd1 <<< msb);
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/cordic_lin_mac_if.sv
// cordic_lin_mac_if: operand and result valid/ready handshakes.
// master = producer/consumer side, slave = the MAC block.
interface cordic_lin_mac_if #(
    parameter int WIDTH = 15
);
    logic           in_valid;
    logic           in_ready;
    logic [WIDTH:0] x_in;
    logic [WIDTH:0] z_in;
    logic [WIDTH:0] y_in;
    logic           out_valid;
    logic           out_ready;
    logic [WIDTH:0] result;

    modport master (
        output in_valid, x_in, z_in, y_in, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, x_in, z_in, y_in, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mux.sv
// mux: 2:1 word select primitive.
// Ports: sel (0 -> in0, 1 -> in1), in0/in1 data, out selected word.
module mux #(
    parameter int WIDTH = 15
) (
    input  logic           sel,
    input  logic [WIDTH:0] in0,
    input  logic [WIDTH:0] in1,
    output logic [WIDTH:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/cordic_lin_mac.sv
// cordic_lin_mac: iterative linear CORDIC, result = y0 + x0*z0.
// Ports: clk, rst (async high), bus (slave: operands in, result out).
module cordic_lin_mac
    import cordic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int ITER  = DEF_ITER,
    parameter int GUARD = DEF_GUARD
) (
    input  logic             clk,
    input  logic             rst,
    cordic_lin_mac_if.slave  bus
);
    localparam int YW = WIDTH + 1 + GUARD;
    localparam int ZW = WIDTH + 2;
    localparam int CW = $clog2(ITER);

    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [CW-1:0] fsh;
    logic          sel;
    logic          load;
    logic          step;
    logic          last;
    logic          d;

    logic signed [WIDTH:0] x_r, x_d;
    logic signed [YW-1:0]  y_r, y_d, y_ld, y_fb;
    logic signed [YW-1:0]  x_ext, x_sh;
    logic signed [ZW-1:0]  z_r, z_d, z_ld, z_fb;
    logic signed [ZW-1:0]  z_step;
    logic [WIDTH:0]        res_r;

    assign sel  = (state == RUN);
    assign last = (cnt == CW'(ITER - 1));

    assign y_ld = {{GUARD{bus.y_in[WIDTH]}}, bus.y_in};
    assign z_ld = {bus.z_in[WIDTH], bus.z_in};

    // Rotation direction drives z toward zero.
    assign d      = ~z_r[ZW-1];
    assign x_ext  = YW'(x_r);
    assign x_sh   = x_ext >>> cnt;
    assign fsh    = CW'(FRAC) - cnt;
    assign z_step = ZW'(1) << fsh;
    assign y_fb   = d ? (y_r + x_sh) : (y_r - x_sh);
    assign z_fb   = d ? (z_r - z_step) : (z_r + z_step);

    mux #(.WIDTH(WIDTH)) u_mux_x (
        .sel (sel),
        .in0 (bus.x_in),
        .in1 (x_r),
        .out (x_d)
    );

    mux #(.WIDTH(YW - 1)) u_mux_y (
        .sel (sel),
        .in0 (y_ld),
        .in1 (y_fb),
        .out (y_d)
    );

    mux #(.WIDTH(ZW - 1)) u_mux_z (
        .sel (sel),
        .in0 (z_ld),
        .in1 (z_fb),
        .out (z_d)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                load = bus.in_valid;
                if (bus.in_valid)
                    state_nx = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            res_r <= '0;
        end else begin
            state <= state_nx;
            if (load || step) begin
                x_r <= x_d;
                y_r <= y_d;
                z_r <= z_d;
            end
            if (load)
                cnt <= '0;
            else if (step)
                cnt <= cnt + CW'(1);
            if (step && last)
                res_r <= (WIDTH + 1)'(saturate(32'(y_fb), WIDTH));
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_r;

endmodule

// File: tb/tb_cordic_lin_mac.sv
// tb_cordic_lin_mac: directed table, handshake sequences and
// randomized checks against an exact-arithmetic MAC model.
module tb_cordic_lin_mac;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_lin_mac_if #(.WIDTH(15)) bus();

    cordic_lin_mac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string nm;
        int    x;
        int    z;
        int    y;
        int    exp;
        int    tol;
    } vec_t;

    vec_t vecs[7];

    int pass_n  = 0;
    int total_n = 0;
    int cyc     = 0;
    int acc_cyc[$];
    int out_q[$];

    always @(posedge clk) begin
        cyc++;
        if (bus.in_valid && bus.in_ready)
            acc_cyc.push_back(cyc);
        if (bus.out_valid && bus.out_ready)
            out_q.push_back(int'($signed(bus.result)));
    end

    task automatic check(input string nm, input int act,
                         input int exp);
        total_n++;
        if (act == exp)
            pass_n++;
        else
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic check_near(input string nm, input int act,
                              input real exp, input int tol);
        real dv;
        dv = real'(act) - exp;
        if (dv < 0.0)
            dv = -dv;
        total_n++;
        if (dv <= real'(tol))
            pass_n++;
        else
            $display("FAIL %s: got %0d want %0.3f +/- %0d",
                     nm, act, exp, tol);
    endtask

    // Exact y + x*z in Q3.12, clamped to the 16-bit range.
    function automatic real ref_mac(input int x, input int z,
                                    input int y);
        real e;
        e = real'(y) + (real'(x) * real'(z)) / 4096.0;
        if (e > 32767.0)
            e = 32767.0;
        if (e < -32768.0)
            e = -32768.0;
        return e;
    endfunction

    task automatic start_op(input int x, input int z, input int y,
                            output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        bus.x_in     = 16'(x);
        bus.z_in     = 16'(z);
        bus.y_in     = 16'(y);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at the negedge after the acceptance edge.
    task automatic wait_done(output int lat, output int r);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        r = int'($signed(bus.result));
    endtask

    task automatic run_op(input string nm, input int x,
                          input int z, input int y,
                          input real exp, input int tol,
                          input bit chk_lat);
        bit ok;
        int lat;
        int r;
        start_op(x, z, y, ok);
        check({nm, "_accept"}, int'(ok), 1);
        wait_done(lat, r);
        if (chk_lat)
            check({nm, "_latency"}, lat, 13);
        check_near({nm, "_result"}, r, exp, tol);
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int lat;
        int r0;
        int n;
        int x;
        int z;
        int y;

        vecs[0] = '{"basic",    6144,  2048, 1024,  4096,  4};
        vecs[1] = '{"signed",  -8192,  3072, 2048, -4096,  4};
        vecs[2] = '{"sat_pos", 28672,  6144,    0, 32767,  0};
        vecs[3] = '{"sat_neg", 28672, -6144,    0, -32768, 0};
        vecs[4] = '{"x_zero",      0,  5000, -1234, -1234, 0};
        vecs[5] = '{"neg_neg", -4096, -4096, -4096,     0, 4};
        vecs[6] = '{"sat_add", 20480,  7000, 32767, 32767, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.x_in      = '0;
        bus.z_in      = '0;
        bus.y_in      = '0;

        #12;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_result", int'(bus.result), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].x, vecs[i].z, vecs[i].y,
                   real'(vecs[i].exp), vecs[i].tol, 1'b1);

        // Backpressure: result parked in DONE for 5 cycles.
        n = acc_cyc.size();
        @(negedge clk);
        bus.out_ready = 1'b0;
        start_op(4096, 2048, 0, ok);
        check("bp_accept", int'(ok), 1);
        wait_done(lat, r0);
        check("bp_latency", lat, 13);
        check_near("bp_result", r0, 2048.0, 4);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.x_in     = 16'(1234);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_hold_result", int'($signed(bus.result)), r0);
            check("bp_hold_in_ready", int'(bus.in_ready), 0);
        end
        check("bp_no_accept", acc_cyc.size(), n + 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(bus.out_valid), 0);
        check("bp_release_in_ready", int'(bus.in_ready), 1);

        // Back-to-back with in_valid held high.
        acc_cyc.delete();
        out_q.delete();
        bus.x_in     = 16'(8192);
        bus.z_in     = 16'(-2048);
        bus.y_in     = 16'(4096);
        bus.in_valid = 1'b1;
        n = 0;
        while (acc_cyc.size() < 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.x_in = 16'(-6144);
        bus.z_in = 16'(-4096);
        bus.y_in = 16'(-2048);
        n = 0;
        while (acc_cyc.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (out_q.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_accepts", acc_cyc.size(), 2);
        check("b2b_results", out_q.size(), 2);
        if (acc_cyc.size() >= 2)
            check("b2b_gap", acc_cyc[1] - acc_cyc[0], 15);
        if (out_q.size() >= 2) begin
            check_near("b2b_first", out_q[0], 0.0, 4);
            check_near("b2b_second", out_q[1], 4096.0, 4);
        end
        @(negedge clk);

        // Reset during the 6th RUN cycle aborts the operation.
        out_q.delete();
        start_op(12288, 4096, 0, ok);
        check("rm_accept", int'(ok), 1);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rm_out_valid", int'(bus.out_valid), 0);
        check("rm_result", int'(bus.result), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rm_in_ready", int'(bus.in_ready), 1);
        check("rm_no_output", out_q.size(), 0);
        run_op("rm_after", 4096, 4096, 0, 4096.0, 4, 1'b1);

        // Randomized operands, |x| < 4.0 and |z| < 2.0.
        for (int k = 0; k < 20; k++) begin
            x = int'($urandom_range(32767, 0)) - 16384;
            z = int'($urandom_range(16382, 0)) - 8191;
            y = int'($urandom_range(65535, 0)) - 32768;
            run_op("rand", x, z, y, ref_mac(x, z, y), 16, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_lin_mac.md
Name: cordic_lin_mac

Overview:
- Iterative linear-mode CORDIC multiply-accumulate that computes result = y0 + x0*z0 in fixed point: one neuron weight×input product added to a partial sum.
- Sits directly upstream of the 2:1 `mux` primitive and instantiates it three times to select, per datapath register, between the freshly loaded operand (sel=0) and the iteration feedback (sel=1).
- Its output feeds the neuron accumulator / activation stage through a valid/ready handshake.

Parameters:
- WIDTH, 15, MSB index of data words; words are WIDTH+1 bits (16) two's complement.
- FRAC, 12, fractional bits of the data format (default Q3.12; 1.0 = 4096).
- ITER, 13, CORDIC iterations, i = 0..ITER-1; must be FRAC+1.
- GUARD, 3, extra MSBs on the internal y accumulator.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- x_in  in  WIDTH+1  multiplicand (neuron input), signed QX.FRAC.
- z_in  in  WIDTH+1  multiplier (weight), signed; legal range |z| < 2.0.
- y_in  in  WIDTH+1  accumulate addend (partial sum), signed.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH+1  saturated y0 + x0*z0, signed.

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, x/y/z registers=0, result=0, out_valid=0. in_ready=1 once rst is deasserted.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1, at the next edge: mux sel=0 loads x←x_in, y←sign-extend(y_in) to WIDTH+1+GUARD bits, z←sign-extend(z_in) to WIDTH+2 bits. Then cnt←0 and state→RUN.
  - RUN: in_ready=0. At each edge, with mux sel=1 on feedback:
    - d = +1 if z≥0, else −1.
    - y ← y + d*(x >>> cnt), using an arithmetic shift of sign-extended x.
    - z ← z − d*(1 << (FRAC−cnt)).
    - cnt ← cnt+1.
    - On the edge where cnt==ITER−1, this update occurs, result is written with saturate(y_next), and state→DONE.
  - DONE: out_valid=1 and in_ready=0. result and out_valid are held stable while out_ready=0. When out_ready=1, at the next edge out_valid←0 and state→IDLE. No new operands are accepted in the same cycle; in_ready only rises in IDLE.
- Latency: acceptance edge k → out_valid high after edge k+ITER (13 cycles). Minimum initiation interval is ITER+2 cycles.
- Saturation: y fits WIDTH+1+GUARD bits without internal overflow for legal inputs. result clamps to +32767 / −32768 when y exceeds the 16-bit range.
- Accuracy: for |z0|<2 and |x0|≤8.0, |result − exact| ≤ 4 LSB before saturation.
- Out-of-range z0 (|z0|≥2): no error flag; result is the deterministic algorithm output. Only saturation behaviour is guaranteed.
- Reset mid-RUN or mid-DONE aborts the operation immediately: out_valid=0, no partial result is emitted, result=0.
- in_valid while busy is ignored; the upstream holds its data because in_ready=0.
- out_ready while not in DONE has no effect.

Decomposition:
- Shared package/header `cordic_pkg`: FRAC, ITER, GUARD defaults, state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and a saturate function.
- Sub-module: the existing `mux` is instantiated three times, with WIDTH set to each register's MSB index, for x/y/z load-versus-feedback select. Sel is driven high in RUN.
- Everything else is in this module: FSM, iteration counter, add/sub datapath, output register.

Test Plan:
- Basic MAC: x=6144 (1.5), z=2048 (0.5), y=1024 (0.25) → result 4096±4, out_valid exactly 13 cycles after acceptance.
- Signed: x=−8192 (−2.0), z=3072 (0.75), y=2048 (0.5) → result −4096±4.
- Saturation: x=28672 (7.0), z=6144 (1.5), y=0 → result 32767. Then x=28672, z=−6144, y=0 → result −32768.
- Backpressure: out_ready held 0 for 5 cycles in DONE → result and out_valid stable, in_ready=0. The in_valid pulse during this window is ignored. out_ready=1 → out_valid drops next edge and in_ready=1.
- Reset mid-operation: assert rst at the 6th RUN cycle → out_valid=0 and result=0 immediately. After release, x=4096, z=4096, y=0 → result 4096±4.
- Back-to-back: in_valid held high with two operand sets, out_ready=1 → the second operand set is accepted exactly ITER+2 cycles after the first and both results are correct.
